// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the unified instruction/data memory port.
// Owner encoding doubles as the bit index into the two-bit request/grant vectors.
package mem_port_arbiter_pkg;

    localparam int MEM_DSIZE = 16;
    localparam int MEM_ISIZE = 16;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int IDX_IF = 0;
    localparam int IDX_DM = 1;

    localparam logic PRIO_RR       = 1'b0;
    localparam logic PRIO_FIXED_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin on ties, or fixed data-port priority.
// Bit 0 is the fetch port, bit 1 the data port.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o
);

    owner_e last_owner_q;
    owner_e last_owner_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            if (mode_i == PRIO_FIXED_DM) begin
                gnt_o = 2'b10;
            end else if (last_owner_q == OWN_DM) begin
                gnt_o = 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end

        last_owner_d = last_owner_q;
        if (gnt_o[IDX_DM]) begin
            last_owner_d = OWN_DM;
        end else if (gnt_o[IDX_IF]) begin
            last_owner_d = OWN_IF;
        end
    end

    // Reset to DM so the first tie after reset goes to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_DM;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port,
// tracks the single outstanding read and routes the returned word to its owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          DSIZE     = MEM_DSIZE,
    parameter int          ISIZE     = MEM_ISIZE,
    parameter int unsigned PRIO_MODE = 0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [ISIZE-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DSIZE-1:0] if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [ISIZE-1:0] dm_addr,
    input  logic [DSIZE-1:0] dm_wdata,
    output logic             dm_gnt,
    output logic             dm_rvalid,
    output logic [DSIZE-1:0] dm_rdata,
    output logic             mem_en,
    output logic             mem_wen,
    output logic [ISIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             cpu_stall,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic ARB_MODE = (PRIO_MODE == 1) ? PRIO_FIXED_DM : PRIO_RR;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       rd_grant;

    logic             rd_pend_q,  rd_pend_d;
    owner_e           rd_owner_q, rd_owner_d;
    logic [DSIZE-1:0] if_rdata_q, if_rdata_d;
    logic [DSIZE-1:0] dm_rdata_q, dm_rdata_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Requests are masked during reset so every output reads zero while it is held.
    assign req = {dm_req, if_req} & {2{~rst}};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .mode_i (ARB_MODE),
        .gnt_o  (gnt)
    );

    assign if_gnt    = gnt[IDX_IF];
    assign dm_gnt    = gnt[IDX_DM];
    assign mem_en    = if_gnt | dm_gnt;
    assign mem_wen   = dm_gnt & dm_we;
    assign rd_grant  = mem_en & ~mem_wen;
    assign cpu_stall = |(req & ~gnt);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr = dm_addr;
            if (dm_we) begin
                mem_wdata = dm_wdata;
            end
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // Returned word is forwarded straight from memory in the rvalid cycle and captured for holding.
    assign if_rvalid = rd_pend_q & (rd_owner_q == OWN_IF);
    assign dm_rvalid = rd_pend_q & (rd_owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;
    assign conflict_cnt = cnt_q;

    always_comb begin
        rd_pend_d  = rd_grant;
        rd_owner_d = rd_owner_q;
        if (rd_grant) begin
            rd_owner_d = dm_gnt ? OWN_DM : OWN_IF;
        end
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        cnt_d      = cnt_q;
        if ((&req) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_IF;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin, fixed-priority and narrow-counter instances
// driven by shared stimulus; the round-robin instance is backed by a synchronous-read memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;

    logic        rr_if_gnt, rr_if_rvalid, rr_dm_gnt, rr_dm_rvalid;
    logic        rr_mem_en, rr_mem_wen, rr_stall;
    logic [15:0] rr_if_rdata, rr_dm_rdata, rr_mem_addr, rr_mem_wdata, rr_cnt;
    logic [15:0] rr_mem_rdata = '0;

    logic        fp_if_gnt, fp_if_rvalid, fp_dm_gnt, fp_dm_rvalid;
    logic        fp_mem_en, fp_mem_wen, fp_stall;
    logic [15:0] fp_if_rdata, fp_dm_rdata, fp_mem_addr, fp_mem_wdata, fp_cnt;

    logic        st_if_gnt, st_if_rvalid, st_dm_gnt, st_dm_rvalid;
    logic        st_mem_en, st_mem_wen, st_stall;
    logic [15:0] st_if_rdata, st_dm_rdata, st_mem_addr, st_mem_wdata;
    logic [3:0]  st_cnt;

    logic [15:0] mem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DSIZE(16), .ISIZE(16), .PRIO_MODE(0), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(rr_if_gnt), .if_rvalid(rr_if_rvalid), .if_rdata(rr_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(rr_dm_gnt), .dm_rvalid(rr_dm_rvalid), .dm_rdata(rr_dm_rdata),
        .mem_en(rr_mem_en), .mem_wen(rr_mem_wen), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_rdata(rr_mem_rdata), .cpu_stall(rr_stall), .conflict_cnt(rr_cnt)
    );

    mem_port_arbiter #(.DSIZE(16), .ISIZE(16), .PRIO_MODE(1), .CNT_W(16)) u_fp (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid), .if_rdata(fp_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(fp_dm_gnt), .dm_rvalid(fp_dm_rvalid), .dm_rdata(fp_dm_rdata),
        .mem_en(fp_mem_en), .mem_wen(fp_mem_wen), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_rdata(16'h5A5A), .cpu_stall(fp_stall), .conflict_cnt(fp_cnt)
    );

    mem_port_arbiter #(.DSIZE(16), .ISIZE(16), .PRIO_MODE(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(st_if_gnt), .if_rvalid(st_if_rvalid), .if_rdata(st_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(st_dm_gnt), .dm_rvalid(st_dm_rvalid), .dm_rdata(st_dm_rdata),
        .mem_en(st_mem_en), .mem_wen(st_mem_wen), .mem_addr(st_mem_addr), .mem_wdata(st_mem_wdata),
        .mem_rdata(16'h5A5A), .cpu_stall(st_stall), .conflict_cnt(st_cnt)
    );

    always @(posedge clk) begin
        if (rr_mem_en) begin
            if (rr_mem_wen) begin
                mem[rr_mem_addr[7:0]] <= rr_mem_wdata;
            end else begin
                rr_mem_rdata <= mem[rr_mem_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia,
                         input logic dr, input logic we, input logic [15:0] da, input logic [15:0] wd);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = we;
        dm_addr  = da;
        dm_wdata = wd;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        mid();
        next();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'hA000 + 16'(i);
        end

        // Reset state
        mid();
        chk("rst_if_gnt", {31'b0, rr_if_gnt}, 0);
        chk("rst_dm_gnt", {31'b0, rr_dm_gnt}, 0);
        chk("rst_rvalid", {30'b0, rr_if_rvalid, rr_dm_rvalid}, 0);
        chk("rst_if_rdata", {16'b0, rr_if_rdata}, 0);
        chk("rst_dm_rdata", {16'b0, rr_dm_rdata}, 0);
        chk("rst_mem_en", {30'b0, rr_mem_en, rr_mem_wen}, 0);
        chk("rst_cnt", {16'b0, rr_cnt}, 0);
        chk("rst_stall", {31'b0, rr_stall}, 0);
        next();
        rst = 1'b0;

        // Fetch only, addresses 0,1,2
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("f0_gnt", {31'b0, rr_if_gnt}, 1);
        chk("f0_addr", {16'b0, rr_mem_addr}, 32'h0);
        chk("f0_stall", {31'b0, rr_stall}, 0);
        chk("f0_rvalid", {31'b0, rr_if_rvalid}, 0);
        next();
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("f1_gnt", {31'b0, rr_if_gnt}, 1);
        chk("f1_rvalid", {31'b0, rr_if_rvalid}, 1);
        chk("f1_rdata", {16'b0, rr_if_rdata}, 32'hA000);
        chk("f1_stall", {31'b0, rr_stall}, 0);
        next();
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("f2_gnt", {31'b0, rr_if_gnt}, 1);
        chk("f2_rdata", {16'b0, rr_if_rdata}, 32'hA001);
        next();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("f3_gnt", {31'b0, rr_if_gnt}, 0);
        chk("f3_mem_en", {31'b0, rr_mem_en}, 0);
        chk("f3_rvalid", {31'b0, rr_if_rvalid}, 1);
        chk("f3_rdata", {16'b0, rr_if_rdata}, 32'hA002);
        chk("f3_stall", {31'b0, rr_stall}, 0);
        next();
        mid();
        chk("f4_rvalid", {31'b0, rr_if_rvalid}, 0);
        chk("f4_hold", {16'b0, rr_if_rdata}, 32'hA002);
        next();

        // Round-robin conflict: fetch addr 3 vs load addr 0x20 for 4 cycles
        reset_pulse();
        drive(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0020, 16'h0);
        mid();
        chk("rr0_gnt", {30'b0, rr_dm_gnt, rr_if_gnt}, 32'b01);
        chk("rr0_stall", {31'b0, rr_stall}, 1);
        next();
        mid();
        chk("rr1_gnt", {30'b0, rr_dm_gnt, rr_if_gnt}, 32'b10);
        chk("rr1_stall", {31'b0, rr_stall}, 1);
        chk("rr1_if_rdata", {15'b0, rr_if_rvalid, rr_if_rdata}, 32'h1A003);
        next();
        mid();
        chk("rr2_gnt", {30'b0, rr_dm_gnt, rr_if_gnt}, 32'b01);
        chk("rr2_dm_rdata", {15'b0, rr_dm_rvalid, rr_dm_rdata}, 32'h1A020);
        chk("rr2_if_rvalid", {31'b0, rr_if_rvalid}, 0);
        next();
        mid();
        chk("rr3_gnt", {30'b0, rr_dm_gnt, rr_if_gnt}, 32'b10);
        chk("rr3_if_rdata", {15'b0, rr_if_rvalid, rr_if_rdata}, 32'h1A003);
        next();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("rr4_dm_rdata", {15'b0, rr_dm_rvalid, rr_dm_rdata}, 32'h1A020);
        chk("rr4_cnt", {16'b0, rr_cnt}, 4);
        chk("rr4_stall", {31'b0, rr_stall}, 0);
        next();

        // Fixed data priority: both request 3 cycles, then data drops
        reset_pulse();
        drive(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0021, 16'h0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk($sformatf("fp%0d_gnt", k), {30'b0, fp_dm_gnt, fp_if_gnt}, 32'b10);
            chk($sformatf("fp%0d_stall", k), {31'b0, fp_stall}, 1);
            next();
        end
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0021, 16'h0);
        mid();
        chk("fp3_gnt", {30'b0, fp_dm_gnt, fp_if_gnt}, 32'b01);
        chk("fp3_stall", {31'b0, fp_stall}, 0);
        chk("fp3_cnt", {16'b0, fp_cnt}, 3);
        next();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        next();

        // Store 0xBEEF to 0x10, then load 0x10
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        mid();
        chk("st_gnt", {31'b0, rr_dm_gnt}, 1);
        chk("st_wen", {31'b0, rr_mem_wen}, 1);
        chk("st_wdata", {16'b0, rr_mem_wdata}, 32'hBEEF);
        chk("st_addr", {16'b0, rr_mem_addr}, 32'h0010);
        next();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h1234);
        mid();
        chk("ld_gnt", {31'b0, rr_dm_gnt}, 1);
        chk("ld_wen", {31'b0, rr_mem_wen}, 0);
        chk("ld_wdata", {16'b0, rr_mem_wdata}, 0);
        chk("st_no_rvalid", {31'b0, rr_dm_rvalid}, 0);
        next();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("ld_rdata", {15'b0, rr_dm_rvalid, rr_dm_rdata}, 32'h1BEEF);
        chk("ld_idle_wen", {30'b0, rr_mem_en, rr_mem_wen}, 0);
        next();

        // Reset the cycle after a read grant
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("mr_gnt", {31'b0, rr_if_gnt}, 1);
        next();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        mid();
        chk("mr_rvalid", {30'b0, rr_if_rvalid, rr_dm_rvalid}, 0);
        chk("mr_rdata", {rr_if_rdata, rr_dm_rdata}, 0);
        chk("mr_cnt", {16'b0, rr_cnt}, 0);
        next();
        rst = 1'b0;
        mid();
        chk("mr_post_rvalid", {30'b0, rr_if_rvalid, rr_dm_rvalid}, 0);
        next();
        drive(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0022, 16'h0);
        mid();
        chk("mr_tie_gnt", {30'b0, rr_dm_gnt, rr_if_gnt}, 32'b01);
        next();

        // Saturation of the 4-bit counter
        reset_pulse();
        drive(1'b1, 16'h0007, 1'b1, 1'b0, 16'h0023, 16'h0);
        for (int k = 0; k < 20; k++) begin
            mid();
            chk($sformatf("sat%0d_cnt", k), {28'b0, st_cnt}, (k < 15) ? k : 15);
            next();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("sat_end_cnt", {28'b0, st_cnt}, 15);
        chk("wide_end_cnt", {16'b0, rr_cnt}, 20);
        chk("idle_stall", {31'b0, rr_stall}, 0);
        next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 16-bit unified memory between the instruction-fetch port and the data load/store port of the CPU.
- Replaces the split instruction/data memories with one array behind a two-requester arbiter.
- Grants one access per cycle, tracks the single outstanding read, routes returned data to its owner and raises a CPU stall while any request waits.
- Sits between PC/fetch, the load/store path and the memory instance.

Parameters:
DSIZE, 16, data word width
ISIZE, 16, memory address width
PRIO_MODE, 0, 0 = round-robin between ports; 1 = data port fixed priority
CNT_W, 16, width of saturating conflict counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  ISIZE  fetch address (PC)
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  if_rdata valid (one-cycle pulse)
if_rdata  output  DSIZE  fetched instruction, held until next fetch return
dm_req  input  1  data access request; held until dm_gnt
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ISIZE  data address (ALU result)
dm_wdata  input  DSIZE  store data
dm_gnt  output  1  data request accepted this cycle
dm_rvalid  output  1  dm_rdata valid (one-cycle pulse, loads only)
dm_rdata  output  DSIZE  load data, held until next load return
mem_en  output  1  memory access strobe
mem_wen  output  1  memory write enable
mem_addr  output  ISIZE  memory address
mem_wdata  output  DSIZE  memory write data
mem_rdata  input  DSIZE  memory read data, valid one cycle after a read strobe
cpu_stall  output  1  (if_req & ~if_gnt) | (dm_req & ~dm_gnt)
conflict_cnt  output  CNT_W  cycles with both requests asserted, saturating

Behaviour:
- Reset (asynchronous): if_gnt = 0, dm_gnt = 0, both rvalid = 0, both rdata = 0, mem_en = 0, mem_wen = 0, conflict_cnt = 0, last_owner = DM (so fetch wins first tie), rd_pend = 0.
- Grant is combinational in the request cycle. At most one of if_gnt/dm_gnt is asserted per cycle.
- mem_en = if_gnt | dm_gnt. mem_wen = dm_gnt & dm_we. mem_addr and mem_wdata are muxed from the granted port. mem_wdata = 0 when the access is not a store.
- Single requester: granted immediately, every cycle, with no bubbles.
- Both requesting, PRIO_MODE = 0: grant the port that is not last_owner. last_owner updates on every grant.
- Both requesting, PRIO_MODE = 1: data port wins. Fetch waits; cpu_stall stays high.
- Read tracking, registered: on a read grant, rd_pend <= 1 and rd_owner <= granted port. The next cycle, the owner's rvalid = 1 and its rdata <= mem_rdata. rd_pend clears unless a new read is granted in the same cycle. Back-to-back reads are supported.
- Load latency is 1 cycle after grant. Store completes in the grant cycle and produces no rvalid.
- The unselected port's rdata holds its previous value.
- Ordering: accesses reach memory in grant order. A store granted in cycle N followed by a load to the same address in cycle N+1 returns the new data.
- A request dropped before grant is a protocol error. The arbiter does not flag it and simply stops considering that port.
- conflict_cnt increments when if_req & dm_req, and saturates at all-ones.
- Reset mid-read: the pending return is discarded and no rvalid is produced after reset deasserts.
- No request: mem_en = 0, cpu_stall = 0, state holds.

Decomposition:
- Shared package: DSIZE/ISIZE constants (existing define file), owner encoding OWN_IF = 0 / OWN_DM = 1, PRIO_MODE encodings.
- Sub-module rr_arb2: two-input round-robin/fixed-priority arbiter. It holds last_owner and has inputs req[1:0] and mode, and output gnt[1:0].
- The read-return tracking, data routing and conflict counter stay in the top-level block.

Test Plan:
- Reset, then fetch-only: if_req = 1 with addresses 0,1,2 on consecutive cycles. Required: if_gnt every cycle, if_rvalid at cycles +1, if_rdata = mem[0], mem[1], mem[2], cpu_stall = 0.
- Conflict, PRIO_MODE = 0: if_req & dm_req (load addr 0x20) held 4 cycles. Required: grants alternate IF, DM, IF, DM, cpu_stall = 1 on losing cycles, conflict_cnt = 4.
- Conflict, PRIO_MODE = 1: both requesting for 3 cycles, dm_req drops at cycle 3. Required: dm_gnt cycles 0–2, if_gnt cycle 3, fetch stalled 3 cycles.
- Store-then-load: store 0xBEEF to 0x10, next cycle load 0x10. Required: mem_wen = 1 only in the store cycle, no dm_rvalid for the store, dm_rvalid with dm_rdata = 0xBEEF one cycle after the load grant.
- Reset asserted the cycle after a read grant. Required: no rvalid, all outputs 0, conflict_cnt = 0. First grant after release goes to fetch in a tie.
- Saturation with CNT_W = 4: hold both requests 20 cycles. Required: conflict_cnt stops at 15 with no wrap.
